// File: rtl/alu_cmd_issuer.sv
// ALU command initiator: queues host operations, issues them one at a time on a
// valid/ready command port, and returns each result (or a div-by-zero/timeout status).
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_a,
  input  logic [3:0] host_b,
  input  logic [1:0] host_op,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [9:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic [8:0] rsp_data,
  input  logic       rsp_valid,
  output logic [8:0] out_result,
  output logic [1:0] out_op,
  output logic       out_valid,
  output logic [1:0] out_err,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_op;

  logic       w_push;
  logic       w_pop;
  logic [9:0] w_head;
  logic       w_head_div0;

  assign host_ready  = (r_count != (AW+1)'(DEPTH));
  assign w_push      = host_valid && host_ready;
  assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
  assign w_head      = r_mem[r_rptr];
  assign w_head_div0 = (w_head[9:8] == 2'b11) && (w_head[7:4] == 4'd0);
  assign busy        = (r_state != ST_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {host_op, host_b, host_a};
  end

  // host_ready comes from the registered count, so a pop in the same cycle never frees a slot early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Command port: a transfer happens on an edge where cmd_valid and cmd_ready are both 1;
  // once raised, cmd_valid and cmd_data stay constant until that transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_op       <= 2'b00;
      cmd_data   <= 10'd0;
      cmd_valid  <= 1'b0;
      out_result <= 9'd0;
      out_op     <= 2'b00;
      out_err    <= 2'b00;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_head_div0) begin
              out_result <= 9'd0;
              out_op     <= 2'b11;
              out_err    <= 2'b01;
              out_valid  <= 1'b1;
            end else begin
              cmd_data  <= w_head;
              cmd_valid <= 1'b1;
              r_state   <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            r_timer   <= '0;
            r_op      <= cmd_data[9:8];
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response on the last timer cycle still counts as a normal return.
          if (rsp_valid) begin
            out_result <= rsp_data;
            out_op     <= r_op;
            out_err    <= 2'b00;
            out_valid  <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            out_result <= 9'h1FF;
            out_op     <= r_op;
            out_err    <= 2'b10;
            out_valid  <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: table of single-operation vectors plus hand-written
// sequences for queue-full, response/timeout tie, stray response and reset in WAIT.
module tb_alu_cmd_issuer;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_a, host_b;
  logic [1:0] host_op;
  logic       host_valid;
  logic       host_ready;
  logic [9:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] rsp_data;
  logic       rsp_valid;
  logic [8:0] out_result;
  logic [1:0] out_op;
  logic       out_valid;
  logic [1:0] out_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         kind;       // 0 normal, 1 div-by-zero, 2 timeout
    int         ready_dly;
    int         rsp_dly;
    logic [8:0] rsp;
    logic [9:0] exp_cmd;
    logic [8:0] exp_res;
    logic [1:0] exp_op;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[8];

  alu_cmd_issuer #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_a     (host_a),
    .host_b     (host_b),
    .host_op    (host_op),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .rsp_data   (rsp_data),
    .rsp_valid  (rsp_valid),
    .out_result (out_result),
    .out_op     (out_op),
    .out_valid  (out_valid),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    @(negedge clk);
    check("push_ready", 32'(host_ready), 32'd1);
    host_a = a; host_b = b; host_op = op; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_cmd(input string name);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cmd_valid), 32'd1);
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("cmd_drop", 32'(cmd_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    push(v.a, v.b, v.op);
    check("issue_not_early", 32'(cmd_valid), 32'd0);
    check("out_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    if (v.kind == 1) begin
      check("div0_no_cmd", 32'(cmd_valid), 32'd0);
      check("div0_pulse", 32'(out_valid), 32'd1);
    end else begin
      check("cmd_latency", 32'(cmd_valid), 32'd1);
      check("cmd_data", 32'(cmd_data), 32'(v.exp_cmd));
      for (int i = 0; i < v.ready_dly; i++) begin
        @(negedge clk);
        check("cmd_hold_valid", 32'(cmd_valid), 32'd1);
        check("cmd_hold_data", 32'(cmd_data), 32'(v.exp_cmd));
      end
      handshake();
      if (v.kind == 0) begin
        for (int i = 0; i < v.rsp_dly; i++) begin
          @(negedge clk);
          check("wait_quiet", 32'(out_valid), 32'd0);
        end
        rsp_valid = 1'b1; rsp_data = v.rsp;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("rsp_pulse", 32'(out_valid), 32'd1);
      end else begin
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
          @(negedge clk);
          n++;
        end
        check("tmo_cycles", 32'(n), 32'(TIMEOUT));
      end
    end
    check("out_result", 32'(out_result), 32'(v.exp_res));
    check("out_err", 32'(out_err), 32'(v.exp_err));
    if (v.kind != 2) check("out_op", 32'(out_op), 32'(v.exp_op));
    @(negedge clk);
    check("pulse_width", 32'(out_valid), 32'd0);
    check("result_hold", 32'(out_result), 32'(v.exp_res));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    logic [3:0] ta, tb_;
    logic [1:0] top;

    //              a     b     op   kind rdy rsp  rsp      cmd      res      op     err
    vecs[0] = '{4'h3, 4'h5, 2'b00, 0,   2,  1, 9'd8,   10'h053, 9'd8,   2'b00, 2'b00};
    vecs[1] = '{4'hF, 4'hF, 2'b10, 0,   0,  3, 9'h0E1, 10'h2FF, 9'd225, 2'b10, 2'b00};
    vecs[2] = '{4'h9, 4'h4, 2'b01, 0,   1,  0, 9'd5,   10'h149, 9'd5,   2'b01, 2'b00};
    vecs[3] = '{4'h8, 4'h2, 2'b11, 0,   0,  5, 9'd4,   10'h328, 9'd4,   2'b11, 2'b00};
    vecs[4] = '{4'h7, 4'h0, 2'b11, 1,   0,  0, 9'd0,   10'h000, 9'd0,   2'b11, 2'b01};
    vecs[5] = '{4'h1, 4'h1, 2'b00, 2,   0,  0, 9'd0,   10'h011, 9'h1FF, 2'b00, 2'b10};
    vecs[6] = '{4'h0, 4'h0, 2'b01, 0,   0,  0, 9'h1FF, 10'h100, 9'h1FF, 2'b01, 2'b00};
    vecs[7] = '{4'hF, 4'h1, 2'b11, 0,   3,  2, 9'd15,  10'h31F, 9'd15,  2'b11, 2'b00};

    reset = 1'b1;
    host_a = '0; host_b = '0; host_op = '0; host_valid = 1'b0;
    cmd_ready = 1'b0; rsp_data = '0; rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_data", 32'(cmd_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_host_ready", 32'(host_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Queue full: one command parks in SEND, four more fill the queue.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ta = 4'(i + 1); tb_ = 4'(i + 2); top = 2'(i % 3);
      host_a = ta; host_b = tb_; host_op = top; host_valid = 1'b1;
      if (host_ready) begin
        acc++;
        exp_q.push_back({top, tb_, ta});
      end
      if (i == 5) check("full_ready_low", 32'(host_ready), 32'd0);
    end
    @(negedge clk);
    host_valid = 1'b0;
    check("full_accepts", 32'(acc), 32'd5);
    check("full_still_low", 32'(host_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 5; j++) begin
      wait_cmd("drain_cmd_valid");
      check("drain_cmd_order", 32'(cmd_data), 32'(exp_q.pop_front()));
      handshake();
      rsp_valid = 1'b1; rsp_data = 9'(j * 10 + 1);
      @(negedge clk);
      rsp_valid = 1'b0;
      check("drain_out_valid", 32'(out_valid), 32'd1);
      check("drain_out_result", 32'(out_result), 32'(j * 10 + 1));
    end
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_no_cmd", 32'(cmd_valid), 32'd0);

    // Response on the same cycle the timer expires.
    push(4'h2, 4'h2, 2'b00);
    wait_cmd("tie_cmd_valid");
    check("tie_cmd_data", 32'(cmd_data), 32'h022);
    handshake();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(negedge clk);
      check("tie_quiet", 32'(out_valid), 32'd0);
    end
    rsp_valid = 1'b1; rsp_data = 9'd4;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("tie_out_valid", 32'(out_valid), 32'd1);
    check("tie_out_err", 32'(out_err), 32'd0);
    check("tie_out_result", 32'(out_result), 32'd4);

    // Stray response while IDLE.
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = 9'h0AA;
    @(negedge clk);
    rsp_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_no_out", 32'(out_valid), 32'd0);
      check("stray_hold", 32'(out_result), 32'd4);
    end

    // Reset while WAITing with commands still queued.
    push(4'h4, 4'h3, 2'b10);
    wait_cmd("rw_cmd_valid");
    handshake();
    push(4'h1, 4'h2, 2'b00);
    push(4'h5, 4'h6, 2'b01);
    check("rw_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_host_ready", 32'(host_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rsp_valid = 1'b1; rsp_data = 9'h055;
    @(negedge clk);
    rsp_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rw_no_out", 32'(out_valid), 32'd0);
      check("rw_no_cmd", 32'(cmd_valid), 32'd0);
    end
    check("rw_out_result", 32'(out_result), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
